tone_period_meter: RTL and testbench

TONE_PERIOD_METER -- requirements
Module: tone_period_meter

---
 rtl/music_pkg.sv | 24 ++
 rtl/tone_period_meter_if.sv | 28 ++
 rtl/tone_sync.sv | 28 ++
 rtl/tone_period_meter.sv | 120 ++++++++++++
 tb/tb_tone_period_meter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the tone measurement blocks.
// Counter width, meter FSM states and the default tone half-period.
package music_pkg;

  localparam int CNT_W      = 16;
  localparam int DEF_TARGET = 28409;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    LOCK
  } state_t;

  function automatic logic in_band(
    input cnt_t p,
    input cnt_t lo,
    input cnt_t hi
  );
    return (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/tone_period_meter_if.sv
// Tone input and measurement results of the period meter.
// master is the meter itself, slave is whoever drives the tone and reads results.
interface tone_period_meter_if;
  import music_pkg::*;

  logic tone_in;
  cnt_t period;
  logic period_valid;
  logic locked;
  logic timeout;

  modport master (
    input  tone_in,
    output period,
    output period_valid,
    output locked,
    output timeout
  );

  modport slave (
    output tone_in,
    input  period,
    input  period_valid,
    input  locked,
    input  timeout
  );

endinterface

// File: rtl/tone_sync.sv
// Two-flop synchronizer for the tone plus a delay flop for edge detect.
// tgl is high for one cycle after either polarity of transition.
module tone_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tgl
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tgl = s2 ^ s3;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period of an asynchronous square-wave tone and
// locks once LOCK_N consecutive half-periods sit within TARGET +/- TOL.
module tone_period_meter
  import music_pkg::*;
#(
  parameter int TARGET  = DEF_TARGET,
  parameter int TOL     = 64,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 65535
) (
  input logic               clk,
  input logic               rst_n,
  tone_period_meter_if.master m
);

  localparam cnt_t       LO     = cnt_t'(TARGET - TOL);
  localparam cnt_t       HI     = cnt_t'(TARGET + TOL);
  localparam cnt_t       TO_END = cnt_t'(TIMEOUT - 1);
  localparam logic [3:0] LOCK_M = 4'(LOCK_N);

  logic       tgl;
  state_t     state_q;
  state_t     state_d;
  cnt_t       cnt_q;
  cnt_t       cnt_d;
  cnt_t       per_q;
  cnt_t       per_d;
  cnt_t       meas;
  logic [3:0] mcnt_q;
  logic [3:0] mcnt_d;
  logic [3:0] mcnt_inc;
  logic       pv_q;
  logic       pv_d;
  logic       to_q;
  logic       to_d;
  logic       lk_q;
  logic       lk_d;

  tone_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (m.tone_in),
    .tgl   (tgl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcnt_q  <= '0;
      per_q   <= '0;
      pv_q    <= 1'b0;
      to_q    <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      per_q   <= per_d;
      pv_q    <= pv_d;
      to_q    <= to_d;
      lk_q    <= lk_d;
    end
  end

  // The edge seen this cycle closes a half-period of cnt+1 cycles.
  assign meas     = cnt_q + cnt_t'(1);
  assign mcnt_inc = (mcnt_q == LOCK_M) ? LOCK_M
                                       : mcnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    per_d   = per_q;
    pv_d    = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        mcnt_d = '0;
        if (tgl) state_d = HUNT;
      end
      HUNT, LOCK: begin
        if (tgl) begin
          cnt_d = '0;
          per_d = meas;
          pv_d  = 1'b1;
          if (in_band(meas, LO, HI)) begin
            mcnt_d  = mcnt_inc;
            state_d = (mcnt_inc == LOCK_M) ? LOCK
                                           : HUNT;
          end else begin
            mcnt_d  = '0;
            state_d = HUNT;
          end
        end else if (cnt_q == TO_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          mcnt_d  = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mcnt_d  = '0;
      end
    endcase
    lk_d = (state_d == LOCK);
  end

  assign m.period       = per_q;
  assign m.period_valid = pv_q;
  assign m.locked       = lk_q;
  assign m.timeout      = to_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter with scaled-down parameters.
// A per-cycle event model plus table rows and directed corner sequences.
module tb_tone_period_meter;
  import music_pkg::*;

  localparam int TGT = 100;
  localparam int TL  = 8;
  localparam int LN  = 4;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tone_period_meter_if tif ();

  tone_period_meter #(
    .TARGET  (TGT),
    .TOL     (TL),
    .LOCK_N  (LN),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (tif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic prev_lvl;
  logic tg1;
  logic tg2;
  bit   active;
  int   start;
  int   streak;
  int   e_per;
  bit   e_pv;
  bit   e_to;
  bit   e_lk;

  int pv_seen = 0;
  int to_seen = 0;
  int last_pv_cyc = 0;
  int to_cyc = 0;

  typedef struct {
    int h;
    int n;
    int per;
    int lk;
    int pulses;
    int tos;
  } row_t;

  row_t rows [9];

  function automatic bit in_tol(input int p);
    return (p >= TGT - TL) && (p <= TGT + TL);
  endfunction

  task automatic check(input string name,
                       input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
               name, act, exp);
    end
  endtask

  // Event model: a tone change sampled at edge k is seen by the meter
  // at edge k+2; periods are differences between those times.
  always @(posedge clk) begin
    bit ev;
    bit tnow;
    cyc++;
    if (!rst_n) begin
      prev_lvl = 1'b0;
      tg1 = 1'b0;
      tg2 = 1'b0;
      active = 0;
      streak = 0;
      e_per = 0;
      e_pv = 0;
      e_to = 0;
      e_lk = 0;
    end else begin
      tnow = (tif.tone_in != prev_lvl);
      prev_lvl = tif.tone_in;
      ev = tg2;
      tg2 = tg1;
      tg1 = tnow;
      e_pv = 0;
      e_to = 0;
      if (ev) begin
        if (active) begin
          e_per = cyc - start;
          e_pv = 1;
          if (in_tol(e_per))
            streak = (streak < LN) ? streak + 1 : LN;
          else
            streak = 0;
        end
        active = 1;
        start = cyc;
      end else if (active && (cyc - start == TMO)) begin
        e_to = 1;
        active = 0;
        streak = 0;
      end
      e_lk = (streak == LN);
    end
    #1;
    checks++;
    if ({tif.period_valid, tif.timeout, tif.locked}
          !== {e_pv, e_to, e_lk}
        || tif.period !== 16'(e_per)) begin
      errors++;
      if (errors <= 30)
        $display("FAIL cycle %0d pv/to/lk/per actual %b%b%b/%0d required %b%b%b/%0d",
                 cyc, tif.period_valid, tif.timeout,
                 tif.locked, tif.period,
                 e_pv, e_to, e_lk, e_per);
    end
    if (tif.period_valid === 1'b1) begin
      pv_seen++;
      last_pv_cyc = cyc;
    end
    if (tif.timeout === 1'b1) begin
      to_seen++;
      to_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tif.tone_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_half(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      tif.tone_in = ~tif.tone_in;
      if (i < n - 1) repeat (h) @(negedge clk);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_period"}, int'(tif.period), 0);
    check({tag, "_pv"}, int'(tif.period_valid), 0);
    check({tag, "_locked"}, int'(tif.locked), 0);
    check({tag, "_timeout"}, int'(tif.timeout), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int t0;
    int k;
    int h;

    rows[0] = '{100, 5, 100, 1, 4, 0};
    rows[1] = '{108, 5, 108, 1, 4, 0};
    rows[2] = '{109, 5, 109, 0, 4, 0};
    rows[3] = '{92,  5, 92,  1, 4, 0};
    rows[4] = '{91,  5, 91,  0, 4, 0};
    rows[5] = '{100, 4, 100, 0, 3, 0};
    rows[6] = '{300, 3, 300, 0, 2, 0};
    rows[7] = '{301, 3, 0,   0, 0, 2};
    rows[8] = '{1,   6, 1,   0, 5, 0};

    tif.tone_in = 1'b0;
    rst_n = 1'b0;
    wait_n(3);
    chk_zero("reset");
    rst_n = 1'b1;

    foreach (rows[r]) begin
      do_reset();
      pv_seen = 0;
      to_seen = 0;
      run_half(rows[r].h, rows[r].n);
      wait_n(4);
      check($sformatf("row%0d_period", r),
            int'(tif.period), rows[r].per);
      check($sformatf("row%0d_locked", r),
            int'(tif.locked), rows[r].lk);
      check($sformatf("row%0d_pulses", r),
            pv_seen, rows[r].pulses);
      check($sformatf("row%0d_timeouts", r),
            to_seen, rows[r].tos);
    end

    // Lock, one short half-period, then relock.
    do_reset();
    run_half(100, 5);
    wait_n(4);
    check("pre_glitch_locked", int'(tif.locked), 1);
    wait_n(56);
    tif.tone_in = ~tif.tone_in;
    wait_n(4);
    check("glitch_period", int'(tif.period), 60);
    check("glitch_locked", int'(tif.locked), 0);
    wait_n(96);
    run_half(100, 3);
    wait_n(4);
    check("relock_3_locked", int'(tif.locked), 0);
    wait_n(96);
    tif.tone_in = ~tif.tone_in;
    wait_n(4);
    check("relock_4_locked", int'(tif.locked), 1);

    // Tone held constant while locked.
    t0 = to_seen;
    for (int i = 0; i < 400 && to_seen == t0; i++)
      @(negedge clk);
    check("lost_timeouts", to_seen - t0, 1);
    check("lost_delay", to_cyc - last_pv_cyc, TMO);
    check("lost_period", int'(tif.period), 100);
    check("lost_locked", int'(tif.locked), 0);

    // Reset mid-period while locked, tone high at release.
    do_reset();
    run_half(100, 5);
    wait_n(50);
    #3 rst_n = 1'b0;
    #1 chk_zero("midrst");
    wait_n(2);
    rst_n = 1'b1;
    p0 = pv_seen;
    wait_n(100);
    tif.tone_in = ~tif.tone_in;
    wait_n(4);
    check("midrst_pulses", pv_seen - p0, 1);
    check("midrst_period", int'(tif.period), 100);

    // Random half-periods and resets against the model.
    do_reset();
    for (int s = 0; s < 150; s++) begin
      k = $urandom_range(0, 9);
      if (k == 9) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        if ($urandom_range(0, 1) == 1)
          tif.tone_in = ~tif.tone_in;
        wait_n(2);
        rst_n = 1'b1;
      end else begin
        if (k <= 4) h = $urandom_range(92, 108);
        else if (k == 5) h = $urandom_range(1, 91);
        else if (k == 6) h = $urandom_range(109, 299);
        else if (k == 7) h = $urandom_range(299, 301);
        else h = $urandom_range(302, 340);
        wait_n(h);
        tif.tone_in = ~tif.tone_in;
      end
    end
    wait_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
